// File: rtl/sram_pkg.sv
// Shared types and elaboration helpers for the burst SRAM controller.
package sram_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Host word must split into a power-of-two number (>= 2) of SRAM beats.
    function automatic bit ratio_ok(input int dw, input int sdw);
        int b;
        if (sdw <= 0 || (dw % sdw) != 0) return 1'b0;
        b = dw / sdw;
        return (b >= 2) && ((b & (b - 1)) == 0);
    endfunction

endpackage

// File: rtl/sram_dq_io.sv
// SRAM data-bus tristate driver and per-beat read-capture register.
module sram_dq_io
    import sram_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SRAM_DW = 16,
    parameter int BEAT_W  = 1
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               i_oe,
    input  logic [SRAM_DW-1:0] i_dout,
    input  logic               i_cap,
    input  logic [BEAT_W-1:0]  i_beat,
    output logic [DATA_W-1:0]  o_rdata,
    inout  tri   [SRAM_DW-1:0] io_dq
);

    logic [DATA_W-1:0] r_rdata;

    assign io_dq   = i_oe ? i_dout : {SRAM_DW{1'bz}};
    assign o_rdata = r_rdata;

    // Beat b lands in slice b, so beat 0 is the least-significant half-word.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_cap) begin
            r_rdata[i_beat*SRAM_DW +: SRAM_DW] <= io_dq;
        end
    end

endmodule

// File: rtl/sram_burst_ctrl.sv
// Splits one DATA_W host access into SRAM_DW-wide beats with programmable wait
// cycles, stalling the pipeline through ready while the burst is in flight.
module sram_burst_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int SRAM_DW   = 16,
    parameter int SRAM_AW   = 18,
    parameter int WAIT_CYC  = 1,
    parameter int BASE_ADDR = 1024
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               ready,
    inout  tri   [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_OE_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N
);

    localparam int BEATS   = DATA_W / SRAM_DW;
    localparam int BEAT_W  = cnt_w(BEATS);
    localparam int WAIT_W  = cnt_w(WAIT_CYC + 1);
    localparam int BEAT_SH = $clog2(BEATS);
    localparam int BYTE_SH = $clog2(DATA_W / 8);

    if (!ratio_ok(DATA_W, SRAM_DW)) begin : g_bad_ratio
        $error("sram_burst_ctrl: DATA_W must be SRAM_DW * 2^k with k >= 1");
    end

    state_t             r_state;
    logic [BEAT_W-1:0]  r_beat;
    logic [WAIT_W-1:0]  r_wait;
    logic               r_wr;
    logic [DATA_W-1:0]  r_wdata;
    logic [SRAM_AW-1:0] r_sram_addr;
    logic               r_we_n;
    logic               r_oe_n;
    logic               r_dq_oe;

    logic [SRAM_AW-1:0] w_base;
    logic               w_beat_end;
    logic               w_last_beat;
    logic               w_cap;

    // Offset wraps modulo 2^ADDR_W; the cast drops bits beyond the SRAM.
    assign w_base      = SRAM_AW'(((addr - ADDR_W'(BASE_ADDR)) >> BYTE_SH) << BEAT_SH);
    assign w_beat_end  = (r_wait == WAIT_W'(WAIT_CYC));
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    assign w_cap       = (r_state == ACCESS) && !r_wr && w_beat_end;

    assign ready     = (r_state == IDLE) ? ~(rd_en | wr_en) : (r_state == DONE);
    assign SRAM_ADDR = r_sram_addr;
    assign SRAM_WE_N = r_we_n;
    assign SRAM_OE_N = r_oe_n;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // r_wdata shifts down one beat at a time so its low slice is always the live DQ value.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_wait      <= '0;
            r_wr        <= 1'b0;
            r_wdata     <= '0;
            r_sram_addr <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        r_state     <= ACCESS;
                        r_wr        <= wr_en;
                        r_beat      <= '0;
                        r_wait      <= '0;
                        r_wdata     <= wdata;
                        r_sram_addr <= w_base;
                        r_we_n      <= ~wr_en;
                        r_oe_n      <= wr_en;
                        r_dq_oe     <= wr_en;
                    end
                end
                ACCESS: begin
                    if (w_beat_end) begin
                        r_wait <= '0;
                        if (w_last_beat) begin
                            r_state <= DONE;
                            r_we_n  <= 1'b1;
                            r_oe_n  <= 1'b1;
                            r_dq_oe <= 1'b0;
                        end else begin
                            r_beat      <= r_beat + BEAT_W'(1);
                            r_sram_addr <= r_sram_addr + SRAM_AW'(1);
                            r_wdata     <= r_wdata >> SRAM_DW;
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    sram_dq_io #(
        .DATA_W  (DATA_W),
        .SRAM_DW (SRAM_DW),
        .BEAT_W  (BEAT_W)
    ) u_dq_io (
        .clock   (clock),
        .rst     (rst),
        .i_oe    (r_dq_oe),
        .i_dout  (r_wdata[SRAM_DW-1:0]),
        .i_cap   (w_cap),
        .i_beat  (r_beat),
        .o_rdata (rdata),
        .io_dq   (SRAM_DQ)
    );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench: a 32-bit/1-wait and a 64-bit/0-wait controller, each on its own SRAM model.
module tb_sram_burst_ctrl;

    logic clock = 1'b0;
    logic rst   = 1'b0;
    always #5 clock = ~clock;

    // 32-bit instance
    logic        wr32 = 1'b0, rd32 = 1'b0;
    logic [31:0] addr32 = '0, wdata32 = '0;
    logic [31:0] rdata32;
    logic        ready32, we_n32, oe_n32, ce_n32, ub_n32, lb_n32;
    logic [17:0] sa32;
    tri   [15:0] dq32;
    logic [15:0] mem32 [0:(1<<18)-1];

    // 64-bit instance
    logic        wr64 = 1'b0, rd64 = 1'b0;
    logic [31:0] addr64 = '0;
    logic [63:0] wdata64 = '0;
    logic [63:0] rdata64;
    logic        ready64, we_n64, oe_n64, ce_n64, ub_n64, lb_n64;
    logic [17:0] sa64;
    tri   [15:0] dq64;
    logic [15:0] mem64 [0:(1<<18)-1];

    sram_burst_ctrl u_dut32 (
        .clock(clock), .rst(rst), .wr_en(wr32), .rd_en(rd32), .addr(addr32), .wdata(wdata32),
        .rdata(rdata32), .ready(ready32), .SRAM_DQ(dq32), .SRAM_ADDR(sa32), .SRAM_WE_N(we_n32),
        .SRAM_OE_N(oe_n32), .SRAM_CE_N(ce_n32), .SRAM_UB_N(ub_n32), .SRAM_LB_N(lb_n32)
    );

    sram_burst_ctrl #(.DATA_W(64), .WAIT_CYC(0)) u_dut64 (
        .clock(clock), .rst(rst), .wr_en(wr64), .rd_en(rd64), .addr(addr64), .wdata(wdata64),
        .rdata(rdata64), .ready(ready64), .SRAM_DQ(dq64), .SRAM_ADDR(sa64), .SRAM_WE_N(we_n64),
        .SRAM_OE_N(oe_n64), .SRAM_CE_N(ce_n64), .SRAM_UB_N(ub_n64), .SRAM_LB_N(lb_n64)
    );

    // Behavioural asynchronous SRAMs: read drives DQ combinationally, write samples on the clock.
    assign dq32 = (!ce_n32 && !oe_n32 && we_n32) ? mem32[sa32] : 16'hzzzz;
    assign dq64 = (!ce_n64 && !oe_n64 && we_n64) ? mem64[sa64] : 16'hzzzz;
    always @(posedge clock) if (!ce_n32 && !we_n32) mem32[sa32] <= dq32;
    always @(posedge clock) if (!ce_n64 && !we_n64) mem64[sa64] <= dq64;

    typedef struct {
        logic [63:0] rd;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32, e64;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat32  = 0;
    int   lat64  = 0;
    int   x_seen = 0;
    bit   oe_seen = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitors: count ready-low cycles, check rdata and stall length when ready returns.
    always @(negedge clock) begin
        if (!rst && $isunknown({ready32, rdata32, sa32, we_n32, oe_n32,
                                ready64, rdata64, sa64, we_n64, oe_n64})) x_seen++;
        if (!oe_n32) oe_seen = 1'b1;
        if (rst) begin
            lat32 = 0;
        end else if (!ready32) begin
            lat32++;
        end else if (lat32 > 0) begin
            if (q32.size() == 0) begin
                chk("sb32_unexpected", 64'(lat32), 64'd0);
            end else begin
                e32 = q32.pop_front();
                chk("sb32_rdata", {32'h0, rdata32}, e32.rd);
                chk("sb32_stall", 64'(lat32), 64'(e32.lat));
            end
            lat32 = 0;
        end
    end

    always @(negedge clock) begin
        if (rst) begin
            lat64 = 0;
        end else if (!ready64) begin
            lat64++;
        end else if (lat64 > 0) begin
            if (q64.size() == 0) begin
                chk("sb64_unexpected", 64'(lat64), 64'd0);
            end else begin
                e64 = q64.pop_front();
                chk("sb64_rdata", rdata64, e64.rd);
                chk("sb64_stall", 64'(lat64), 64'(e64.lat));
            end
            lat64 = 0;
        end
    end

    task automatic op32(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
        exp_t e;
        int   n;
        e.rd  = {32'h0, exp_rd};
        e.lat = 5;
        q32.push_back(e);
        @(posedge clock); #1;
        wr32 = w; rd32 = r; addr32 = a; wdata32 = d;
        n = 0;
        do begin @(negedge clock); n++; end while (!ready32 && n < 50);
        if (!ready32) chk("op32_timeout", 64'(ready32), 64'd1);
        @(posedge clock); #1;
        wr32 = 1'b0; rd32 = 1'b0;
    endtask

    task automatic op64(input logic w, input logic r, input logic [31:0] a,
                        input logic [63:0] d, input logic [63:0] exp_rd);
        exp_t e;
        int   n;
        e.rd  = exp_rd;
        e.lat = 5;
        q64.push_back(e);
        @(posedge clock); #1;
        wr64 = w; rd64 = r; addr64 = a; wdata64 = d;
        n = 0;
        do begin @(negedge clock); n++; end while (!ready64 && n < 50);
        if (!ready64) chk("op64_timeout", 64'(ready64), 64'd1);
        @(posedge clock); #1;
        wr64 = 1'b0; rd64 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << 18); i++) begin
            mem32[i] = 16'h0000;
            mem64[i] = 16'h0000;
        end
        #1 rst = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_rdata",  {32'h0, rdata32}, 64'h0);
        chk("rst_addr",   64'(sa32), 64'h0);
        chk("rst_we_n",   64'(we_n32), 64'h1);
        chk("rst_oe_n",   64'(oe_n32), 64'h1);
        chk("rst_dq_z",   64'(dq32 === 16'hzzzz), 64'h1);
        chk("rst_ready",  64'(ready32), 64'h1);
        chk("rst_rdata64", rdata64, 64'h0);
        @(posedge clock); #1 rst = 1'b0;

        // Basic write then read back, rdata held across later writes
        op32(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'h0);
        chk("t1_mem0", 64'(mem32[0]), 64'hBEEF);
        chk("t1_mem1", 64'(mem32[1]), 64'hDEAD);
        op32(1'b0, 1'b1, 32'd1024, 32'h0, 32'hDEADBEEF);
        op32(1'b1, 1'b0, 32'd1036, 32'h11112222, 32'hDEADBEEF);
        op32(1'b1, 1'b0, 32'd1040, 32'h33334444, 32'hDEADBEEF);
        op32(1'b1, 1'b0, 32'd1044, 32'h55556666, 32'hDEADBEEF);
        chk("t2_mem6", 64'(mem32[6]), 64'h2222);
        chk("t2_mem11", 64'(mem32[11]), 64'h5555);

        // Simultaneous read and write: write wins, no read strobe
        oe_seen = 1'b0;
        op32(1'b1, 1'b1, 32'd1028, 32'h00000001, 32'hDEADBEEF);
        chk("t4_mem2", 64'(mem32[2]), 64'h0001);
        chk("t4_mem3", 64'(mem32[3]), 64'h0000);
        chk("t4_no_oe", 64'(oe_seen), 64'h0);

        // Reset during cycle 2 of a write: only beat 0 reached the SRAM
        @(posedge clock); #1;
        wr32 = 1'b1; addr32 = 32'd1028; wdata32 = 32'hAAAA5555;
        @(posedge clock);
        @(posedge clock); #1;
        rst = 1'b1; wr32 = 1'b0;
        @(negedge clock);
        chk("t5_we_n",  64'(we_n32), 64'h1);
        chk("t5_dq_z",  64'(dq32 === 16'hzzzz), 64'h1);
        chk("t5_ready", 64'(ready32), 64'h1);
        @(posedge clock); #1 rst = 1'b0;
        op32(1'b0, 1'b1, 32'd1028, 32'h0, 32'h00005555);

        // Address beyond the SRAM wraps to word 0
        op32(1'b1, 1'b0, 32'h0008_0400, 32'hCAFEF00D, 32'h00005555);
        chk("t6_mem0", 64'(mem32[0]), 64'hF00D);
        chk("t6_mem1", 64'(mem32[1]), 64'hCAFE);
        op32(1'b0, 1'b1, 32'h0008_0400, 32'h0, 32'hCAFEF00D);

        // 64-bit host word, no wait cycles
        op64(1'b1, 1'b0, 32'd1032, 64'h0123_4567_89AB_CDEF, 64'h0);
        chk("t3_mem4", 64'(mem64[4]), 64'hCDEF);
        chk("t3_mem5", 64'(mem64[5]), 64'h89AB);
        chk("t3_mem6", 64'(mem64[6]), 64'h4567);
        chk("t3_mem7", 64'(mem64[7]), 64'h0123);
        op64(1'b0, 1'b1, 32'd1032, 64'h0, 64'h0123_4567_89AB_CDEF);

        repeat (3) @(negedge clock);
        chk("sb32_drained", 64'(q32.size()), 64'd0);
        chk("sb64_drained", 64'(q64.size()), 64'd0);
        chk("no_x_outputs", 64'(x_seen), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
